// File: rtl/arc4_param.sv
// rtl/arc4_param.sv - single-FSM ARC4 decrypt engine with configurable key length and keystream drop
module arc4_param #(
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren
);

  localparam int                KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
  localparam logic [9:0]        DROP_LAST = 10'(DROP_N);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_LEN,
    S_KSA_RI, S_KSA_RJ, S_KSA_WI, S_KSA_WJ,
    S_P_RI, S_P_RJ, S_P_WI, S_P_WJ, S_P_RK, S_P_X,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d;
  logic [7:0]        j_q, j_d;
  logic [8:0]        k_q, k_d;
  logic [9:0]        drop_q, drop_d;
  logic [KIDX_W-1:0] kidx_q, kidx_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;

  logic [7:0]        key_byte;
  logic [7:0]        j_new;
  logic [8:0]        k_new;
  logic [9:0]        drop_new;

  // Pick the key byte addressed by the key index; byte 0 is the most significant byte.
  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (kidx_q == KIDX_W'(n)) key_byte = key[8*(KEY_BYTES-1-n) +: 8];
    end
  end

  // Next-state and output decode; reset forces idle-looking outputs so in-flight writes are dropped.
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    drop_d    = drop_q;
    kidx_d    = kidx_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    j_new     = '0;
    k_new     = '0;
    drop_new  = '0;
    rdy       = 1'b0;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy = 1'b1;
        if (en) begin
          state_d = S_INIT;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          drop_d  = '0;
          kidx_d  = '0;
        end
      end
      S_INIT: begin
        s_addr   = i_q;
        s_wrdata = i_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;
        if (i_q == 8'hFF) state_d = S_LEN;
      end
      S_LEN: begin
        len_d     = ct_rddata;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        i_d       = '0;
        j_d       = '0;
        state_d   = S_KSA_RI;
      end
      S_KSA_RI: begin
        s_addr  = i_q;
        state_d = S_KSA_RJ;
      end
      S_KSA_RJ: begin
        si_d    = s_rddata;
        j_new   = j_q + s_rddata + key_byte;
        j_d     = j_new;
        s_addr  = j_new;
        state_d = S_KSA_WI;
      end
      S_KSA_WI: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = S_KSA_WJ;
      end
      S_KSA_WJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        i_d      = i_q + 8'd1;
        kidx_d   = (kidx_q == KIDX_LAST) ? '0 : kidx_q + 1'b1;
        if (i_q == 8'hFF) begin
          i_d     = '0;
          j_d     = '0;
          k_d     = 9'd1;
          // Nothing to drop and an empty message: skip PRGA entirely.
          state_d = (drop_q == DROP_LAST && len_q == 8'd0) ? S_DONE : S_P_RI;
        end else begin
          state_d = S_KSA_RI;
        end
      end
      S_P_RI: begin
        i_d     = i_q + 8'd1;
        s_addr  = i_q + 8'd1;
        state_d = S_P_RJ;
      end
      S_P_RJ: begin
        si_d    = s_rddata;
        j_new   = j_q + s_rddata;
        j_d     = j_new;
        s_addr  = j_new;
        state_d = S_P_WI;
      end
      S_P_WI: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = S_P_WJ;
      end
      S_P_WJ: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = S_P_RK;
      end
      S_P_RK: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q[7:0];
        state_d = S_P_X;
      end
      S_P_X: begin
        if (drop_q != DROP_LAST) begin
          drop_new = drop_q + 10'd1;
          k_new    = k_q;
        end else begin
          pt_addr   = k_q[7:0];
          pt_wrdata = s_rddata ^ ct_rddata;
          pt_wren   = 1'b1;
          k_new     = k_q + 9'd1;
          drop_new  = drop_q;
        end
        drop_d  = drop_new;
        k_d     = k_new;
        state_d = (drop_new == DROP_LAST && k_new > {1'b0, len_q}) ? S_DONE : S_P_RI;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      rdy       = 1'b1;
      s_addr    = '0;
      s_wrdata  = '0;
      s_wren    = 1'b0;
      ct_addr   = '0;
      pt_addr   = '0;
      pt_wrdata = '0;
      pt_wren   = 1'b0;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      drop_q  <= '0;
      kidx_q  <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      drop_q  <= drop_d;
      kidx_q  <= kidx_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

endmodule

// File: tb/tb_arc4_param.sv
// tb/tb_arc4_param.sv - self-checking bench for arc4_param against a behavioural RC4 model
module tb_arc4_param;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en [NI];
  logic        rdy [NI];
  logic [23:0] key_a, key_c;
  logic [39:0] key_b;
  logic [7:0]  s_addr [NI], s_rd [NI], s_wrdata [NI];
  logic [7:0]  ct_addr [NI], ct_rd [NI];
  logic [7:0]  pt_addr [NI], pt_wrdata [NI];
  logic        s_wren [NI], pt_wren [NI];

  logic [7:0]  s_mem [NI][256];
  logic [7:0]  ct_mem [NI][256];
  logic [7:0]  pt_mem [NI][256];
  int          pt_cnt [NI];

  int          checks = 0;
  int          errors = 0;
  int          mkey [32];
  int          ms [256];
  int          ks [256];
  logic [7:0]  ptref [256];

  always #5 clk = ~clk;

  arc4_param #(.KEY_BYTES(3), .DROP_N(0)) dut_a (
    .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]), .key(key_a),
    .s_addr(s_addr[0]), .s_rddata(s_rd[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]),
    .ct_addr(ct_addr[0]), .ct_rddata(ct_rd[0]),
    .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0]));

  arc4_param #(.KEY_BYTES(5), .DROP_N(0)) dut_b (
    .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]), .key(key_b),
    .s_addr(s_addr[1]), .s_rddata(s_rd[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]),
    .ct_addr(ct_addr[1]), .ct_rddata(ct_rd[1]),
    .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1]));

  arc4_param #(.KEY_BYTES(3), .DROP_N(768)) dut_c (
    .clk(clk), .rst(rst), .en(en[2]), .rdy(rdy[2]), .key(key_c),
    .s_addr(s_addr[2]), .s_rddata(s_rd[2]), .s_wrdata(s_wrdata[2]), .s_wren(s_wren[2]),
    .ct_addr(ct_addr[2]), .ct_rddata(ct_rd[2]),
    .pt_addr(pt_addr[2]), .pt_wrdata(pt_wrdata[2]), .pt_wren(pt_wren[2]));

  // Synchronous-read memories for each instance, plus a count of plaintext writes.
  always @(posedge clk) begin
    for (int n = 0; n < NI; n++) begin
      if (s_wren[n]) s_mem[n][s_addr[n]] <= s_wrdata[n];
      s_rd[n]  <= s_mem[n][s_addr[n]];
      ct_rd[n] <= ct_mem[n][ct_addr[n]];
      if (pt_wren[n]) begin
        pt_mem[n][pt_addr[n]] <= pt_wrdata[n];
        pt_cnt[n] <= pt_cnt[n] + 1;
      end
    end
  end

  function automatic int kb_of(input int n);
    return (n == 1) ? 5 : 3;
  endfunction

  function automatic int dn_of(input int n);
    return (n == 2) ? 768 : 0;
  endfunction

  // Plain RC4: KSA, then drop+len PRGA bytes; keeps the last len bytes and the final S.
  function automatic void model(input int klen, input int drop, input int len);
    int s [256];
    int i, j, tmp;
    for (int a = 0; a < 256; a++) s[a] = a;
    j = 0;
    for (int a = 0; a < 256; a++) begin
      j = (j + s[a] + mkey[a % klen]) % 256;
      tmp = s[a]; s[a] = s[j]; s[j] = tmp;
    end
    i = 0;
    j = 0;
    for (int t = 0; t < drop + len; t++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      if (t >= drop) ks[t - drop] = s[(s[i] + s[j]) % 256];
    end
    for (int a = 0; a < 256; a++) ms[a] = s[a];
  endfunction

  task automatic set_key(input int n, input logic [39:0] kv);
    int klen;
    klen = kb_of(n);
    for (int b = 0; b < klen; b++) mkey[b] = int'(kv[8*(klen-1-b) +: 8]);
    case (n)
      0:       key_a = kv[23:0];
      1:       key_b = kv;
      default: key_c = kv[23:0];
    endcase
  endtask

  task automatic fill_random(input int len);
    for (int b = 1; b <= len; b++) ptref[b] = 8'($urandom);
  endtask

  // Encrypt ptref with the model, run the DUT on it, and check output, timing and S state.
  task automatic run(input int n, input logic [39:0] kv, input int len, input bit toggle_en, input string tag);
    int drop, cnt, bad, exp_cnt;
    drop = dn_of(n);
    set_key(n, kv);
    model(kb_of(n), drop, len);
    @(negedge clk);
    ct_mem[n][0] = 8'(len);
    for (int b = 1; b <= len; b++) ct_mem[n][b] = ptref[b] ^ 8'(ks[b-1]);
    for (int b = 0; b < 256; b++) pt_mem[n][b] <= 8'hEE;
    pt_cnt[n] <= 0;
    en[n] = 1'b1;
    @(negedge clk);
    en[n] = 1'b0;
    cnt = 0;
    while (rdy[n] !== 1'b1 && cnt < 20000) begin
      cnt++;
      en[n] = (toggle_en && cnt < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    en[n] = 1'b0;
    exp_cnt = 256 + 1 + 1024 + 6 * (drop + len) + 1;
    checks++;
    if (cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", tag, cnt, exp_cnt);
    end
    checks++;
    if (pt_mem[n][0] !== 8'(len)) begin
      errors++;
      $display("FAIL %s pt0: got %h expected %h", tag, pt_mem[n][0], 8'(len));
    end
    bad = 0;
    for (int b = 1; b <= len; b++) begin
      if (pt_mem[n][b] !== ptref[b]) begin
        if (bad == 0) $display("FAIL %s pt[%0d]: got %h expected %h", tag, b, pt_mem[n][b], ptref[b]);
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s plaintext: %0d bytes wrong, expected 0", tag, bad);
    end
    checks++;
    if (pt_cnt[n] !== len + 1) begin
      errors++;
      $display("FAIL %s pt_writes: got %0d expected %0d", tag, pt_cnt[n], len + 1);
    end
    if (len < 255) begin
      checks++;
      if (pt_mem[n][len+1] !== 8'hEE) begin
        errors++;
        $display("FAIL %s pt_overrun: got %h expected ee", tag, pt_mem[n][len+1]);
      end
    end
    bad = 0;
    for (int b = 0; b < 256; b++) if (s_mem[n][b] !== 8'(ms[b])) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s s_final: %0d entries wrong, expected 0", tag, bad);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int n = 0; n < NI; n++) begin
      checks++;
      if (rdy[n] !== 1'b1 || s_wren[n] !== 1'b0 || pt_wren[n] !== 1'b0) begin
        errors++;
        $display("FAIL reset_ctrl[%0d]: got rdy=%b s_wren=%b pt_wren=%b expected 1 0 0", n, rdy[n], s_wren[n], pt_wren[n]);
      end
      checks++;
      if ({s_addr[n], s_wrdata[n], ct_addr[n], pt_addr[n], pt_wrdata[n]} !== 40'd0) begin
        errors++;
        $display("FAIL reset_bus[%0d]: got %h %h %h %h %h expected all 0", n, s_addr[n], s_wrdata[n], ct_addr[n], pt_addr[n], pt_wrdata[n]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_vector_key3();
    fill_random(8'h35);
    run(0, 40'h000018, 8'h35, 1'b0, "key3_L53");
  endtask

  task automatic test_key5_abc();
    ptref[1] = 8'h61; ptref[2] = 8'h62; ptref[3] = 8'h63;
    run(1, 40'h0102030405, 3, 1'b0, "key5_abc");
    checks++;
    if ({pt_mem[1][1], pt_mem[1][2], pt_mem[1][3]} !== 24'h616263) begin
      errors++;
      $display("FAIL key5_abc_ascii: got %h%h%h expected 616263", pt_mem[1][1], pt_mem[1][2], pt_mem[1][3]);
    end
    fill_random(37);
    run(1, {8'($urandom), 32'($urandom)}, 37, 1'b0, "key5_rand");
  endtask

  task automatic test_drop();
    fill_random(8'h35);
    run(2, 40'h000018, 8'h35, 1'b0, "drop768");
  endtask

  task automatic test_len_zero();
    run(0, 40'(24'($urandom)), 0, 1'b0, "len0_nodrop");
    run(2, 40'(24'($urandom)), 0, 1'b0, "len0_drop");
  endtask

  task automatic test_reset_mid();
    set_key(0, 40'h00ABCD);
    @(negedge clk);
    en[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0;
    repeat (600) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (s_wren[0] !== 1'b0 || pt_wren[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wren: got s_wren=%b pt_wren=%b expected 0 0", s_wren[0], pt_wren[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_rdy: got %b expected 1", rdy[0]);
    end
    fill_random(20);
    run(0, 40'h00ABCD, 20, 1'b0, "after_rst");
  endtask

  task automatic test_busy_en();
    fill_random(12);
    run(1, {8'($urandom), 32'($urandom)}, 12, 1'b1, "busy_en");
  endtask

  task automatic test_max_len();
    fill_random(255);
    run(0, 40'(24'($urandom)), 255, 1'b0, "len255");
  endtask

  initial begin
    rst = 1'b1;
    for (int n = 0; n < NI; n++) en[n] = 1'b0;
    key_a = '0;
    key_b = '0;
    key_c = '0;
    test_reset();
    test_vector_key3();
    test_key5_abc();
    test_drop();
    test_len_zero();
    test_reset_mid();
    test_busy_en();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/arc4_param.md
# arc4_param

Parametrised single-FSM ARC4 decrypt engine for length-prefixed messages. It has a configurable key length and an optional RC4-drop[N] keystream discard. It runs S-box init, key scheduling and keystream generation/XOR on one externally instanced 256x8 S memory, reading ciphertext memory and writing plaintext memory. It is the drop-in successor of the fixed 24-bit ARC4 top used by the cracker, with its three sub-engines folded into one state machine.

## Interface
Parameters:
- KEY_BYTES, 3: key length in bytes, 1..32; key byte n = key[8*(KEY_BYTES-1-n) +: 8] (byte 0 is the MSB byte).
- DROP_N, 0: keystream bytes generated and discarded before the first message byte, 0..1023.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  start request; sampled only when rdy=1.
- rdy  out  1  high when idle and able to accept en.
- key  in  8*KEY_BYTES  key; must be held stable while rdy=0.
- s_addr  out  8  S memory address.
- s_rddata  in  8  S memory read data.
- s_wrdata  out  8  S memory write data.
- s_wren  out  1  S memory write enable.
- ct_addr  out  8  ciphertext memory address.
- ct_rddata  in  8  ciphertext read data.
- pt_addr  out  8  plaintext memory address.
- pt_wrdata  out  8  plaintext write data.
- pt_wren  out  1  plaintext write enable.

All memories are synchronous read: an address presented in cycle t is valid on the read-data input in cycle t+1.

## Operation
- Message format: ct[0] = L (0..255), ct[1..L] = ciphertext. Output: pt[0] = L, pt[1..L] = plaintext.
- States: IDLE, INIT, LEN, KSA_RI, KSA_RJ, KSA_WI, KSA_WJ, P_RI, P_RJ, P_WI, P_WJ, P_RK, P_X, DONE.
- IDLE: rdy=1, all wren=0. On en=1, go to INIT and clear i, j, k, drop counter and key index.
- INIT: write S[i]=i for i=0..255, one per cycle. Hold ct_addr=0. After i=255, go to LEN.
- LEN: latch L=ct_rddata. Write pt[0]=L (pt_addr=0, pt_wren=1). Go to KSA_RI with i=j=0.
- KSA, per i:
  - KSA_RI: s_addr=i.
  - KSA_RJ: latch si=s_rddata; j=j+si+keybyte[i mod KEY_BYTES]; s_addr=new j.
  - KSA_WI: latch sj; write S[i]=sj.
  - KSA_WJ: write S[j]=si; advance i and key index. Key index wraps at KEY_BYTES via a counter, not a divider.
  - After i=255 wraps to 0, go to P_RI with i=j=0 and k=1.
- PRGA, per byte:
  - P_RI: i=i+1; s_addr=i+1.
  - P_RJ: latch si; j=j+si; s_addr=new j.
  - P_WI: latch sj; write S[i]=sj.
  - P_WJ: write S[j]=si.
  - P_RK: s_addr=si+sj (mod 256); ct_addr=k.
  - P_X: pad=s_rddata. If the drop counter < DROP_N, increment the drop counter with no pt write. Otherwise write pt[k]=pad^ct_rddata and increment k.
  - After P_X, go to DONE if the drop counter == DROP_N and k > L (taking the just-written byte into account); otherwise go to P_RI.
- DONE: one cycle, wren=0, then IDLE.
- All index arithmetic is 8-bit modulo 256. k is 9-bit so L=255 terminates. The drop counter is 10-bit.
- L=0: the drop bytes still run; no pt write beyond pt[0].
- en while rdy=0: ignored. en held high in IDLE: a new run starts each time IDLE is reached.
- rst at any time, including mid-KSA or mid-PRGA: state returns to IDLE next edge, in-flight writes are suppressed, memory contents are left as-is.

## Timing
- Reset values of all outputs (rst=1): rdy=1; s_wren=pt_wren=0; s_addr=s_wrdata=ct_addr=pt_addr=pt_wrdata=0.
- Outputs are decoded from registered state and counters; there are no combinational paths from inputs to outputs except s_wrdata, pt_wrdata and s_addr in P_RJ/KSA_RJ.
- rdy falls the cycle after en is accepted.
- rdy is low for exactly 256 + 1 + 1024 + 6*(DROP_N+L) + 1 cycles, then high.
- At most one S write per cycle. pt_wren is high in exactly L+1 cycles per run.

## Test plan
- key=24'h000018, DROP_N=0, ct = known 3-byte-key vector (L=0x35) -> pt matches the reference plaintext byte-for-byte, pt[0]=0x35, rdy low for 256+1+1024+6*53+1=1600 cycles.
- KEY_BYTES=5, key=40'h0102030405, ct encrypting ASCII "abc" (L=3) -> pt[1..3]=61 62 63; key index wraps 0..4 correctly.
- DROP_N=768, same vector re-encrypted with drop-768 -> plaintext correct; pt_wren pulses only 1+L times.
- L=0 -> only pt[0]=0 written; rdy returns after 1282+6*DROP_N cycles.
- rst pulsed mid-KSA, then a new en -> rdy=1 the cycle after rst, no s_wren/pt_wren during rst, second run output correct.
- en toggled while busy -> no effect; L=255 run -> pt[255] written, k stops, no pt_addr wrap to 0.
